// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed scan controller for a 4-digit seven-segment display.
// Latches a 16-bit hex value, presents one nibble per slot on w,x,y,z and drives the
// active-low anodes an0..an3. Each slot opens with an all-anodes-off guard so the
// nibble can settle before its anode turns on. Staged values reach the display only
// at frame boundaries, so a frame never mixes old and new digits.
// Optional feature: define SEG7_LZB_EN for leading-zero blanking of digits 1..3.
module seg7_scan_driver #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int SCAN_HZ      = 1_000,
  parameter int GUARD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] value_in,
  output logic        w,
  output logic        x,
  output logic        y,
  output logic        z,
  output logic        an0,
  output logic        an1,
  output logic        an2,
  output logic        an3,
  output logic        pending,
  output logic        frame_tick
);

  localparam int              SLOT_CYCLES = CLK_HZ / SCAN_HZ;
  localparam int              CW          = $clog2(SLOT_CYCLES);
  localparam logic [CW-1:0]   LAST_CNT    = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0]   GUARD_LAST  = CW'(GUARD_CYCLES - 1);

  typedef enum logic {GUARD, ON} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [15:0]   staged_q, staged_d;
  logic          pending_d;
  logic          boundary;
  logic          lit;
  logic [3:0]    an_d;
  logic [3:0]    nib_d;
  logic          tick_d;

  // Last cycle of the digit-3 ON phase: where staged values are committed.
  assign boundary = (state_q == ON) && (cnt_q == LAST_CNT) && (idx_q == 2'd3);

  // State register: slot phase, cycle-within-slot counter and digit index.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= GUARD;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic: GUARD -> ON after the guard, ON -> GUARD of next digit at slot end.
  // NOTE: defaults at the top of every always_comb keep each path assigned, so no latches.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    case (state_q)
      GUARD: if (cnt_q == GUARD_LAST) state_d = ON;
      ON: begin
        if (cnt_q == LAST_CNT) begin
          state_d = GUARD;
          cnt_d   = '0;
          idx_d   = idx_q + 1'b1;
        end
      end
      default: state_d = GUARD;
    endcase
  end

  // Value path: loads go to staging; the boundary commits staging (or bypasses a same-cycle load).
  always_comb begin
    shadow_d  = shadow_q;
    staged_d  = staged_q;
    pending_d = pending;
    if (boundary) begin
      pending_d = 1'b0;
      if (load) begin
        shadow_d = value_in;
        staged_d = value_in;
      end else if (pending) begin
        shadow_d = staged_q;
      end
    end else if (load) begin
      staged_d  = value_in;
      pending_d = 1'b1;
    end
  end

  // Output logic: computed from next-state values so the registered outputs line up with the state.
  always_comb begin
`ifdef SEG7_LZB_EN
    lit = (idx_d == 2'd0) || ((shadow_d >> {idx_d, 2'b00}) != 16'h0000);
`else
    lit = 1'b1;
`endif
    nib_d  = shadow_d[{idx_d, 2'b00} +: 4];
    an_d   = 4'b1111;
    tick_d = (state_d == ON) && (cnt_d == LAST_CNT) && (idx_d == 2'd3);
    if ((state_d == ON) && lit) an_d[idx_d] = 1'b0;
  end

  // Output register: anodes, nibble and frame pulse are all driven from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {an3, an2, an1, an0} <= 4'b1111;
      {w, x, y, z}         <= 4'b0000;
      frame_tick           <= 1'b0;
    end else begin
      {an3, an2, an1, an0} <= an_d;
      {w, x, y, z}         <= nib_d;
      frame_tick           <= tick_d;
    end
  end

  // Value registers: displayed shadow, staging buffer and its pending flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= 16'h0000;
      staged_q <= 16'h0000;
      pending  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      staged_q <= staged_d;
      pending  <= pending_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed bench for seg7_scan_driver with a cycle-level
// reference model (slot position derived arithmetically from elapsed cycles).
module tb_seg7_scan_driver;

  localparam int CLK_HZ  = 100;
  localparam int SCAN_HZ = 10;
  localparam int GUARD   = 2;
  localparam int SLOT    = CLK_HZ / SCAN_HZ;
  localparam int FRAME   = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] value_in;
  logic        w, x, y, z, an0, an1, an2, an3, pending, frame_tick;
  logic [3:0]  an_vec, wxyz;

  int tests = 0;
  int fails = 0;

  // Reference model state: cycles since reset, displayed value, staged value, pending flag.
  int          t;
  logic [15:0] m_shadow, m_staged;
  logic        m_pend;

  assign an_vec = {an3, an2, an1, an0};
  assign wxyz   = {w, x, y, z};

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .CLK_HZ      (CLK_HZ),
    .SCAN_HZ     (SCAN_HZ),
    .GUARD_CYCLES(GUARD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .value_in  (value_in),
    .w         (w),
    .x         (x),
    .y         (y),
    .z         (z),
    .an0       (an0),
    .an1       (an1),
    .an2       (an2),
    .an3       (an3),
    .pending   (pending),
    .frame_tick(frame_tick)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0d)", name, act, exp, t);
    end
  endtask

  // Expected {an3..an0, wxyz, pending, frame_tick} for cycle tt.
  function automatic logic [9:0] expect_out(input int tt, input logic [15:0] sh, input logic pd);
    int         p, d;
    logic [3:0] a, n;
    logic       lit;
    p   = tt % SLOT;
    d   = (tt / SLOT) % 4;
    n   = sh[4*d +: 4];
    a   = 4'hF;
    lit = 1'b1;
`ifdef SEG7_LZB_EN
    if (d > 0 && (sh >> (4*d)) == 16'h0000) lit = 1'b0;
`endif
    if (p >= GUARD && lit) a[d] = 1'b0;
    return {a, n, pd, (tt % FRAME) == (FRAME - 1)};
  endfunction

  // Model update: frame boundary is the last cycle of every FRAME-cycle period.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t        <= 0;
      m_shadow <= 16'h0000;
      m_staged <= 16'h0000;
      m_pend   <= 1'b0;
    end else begin
      t <= t + 1;
      if ((t % FRAME) == FRAME - 1) begin
        m_pend <= 1'b0;
        if (load) begin
          m_shadow <= value_in;
          m_staged <= value_in;
        end else if (m_pend) begin
          m_shadow <= m_staged;
        end
      end else if (load) begin
        m_staged <= value_in;
        m_pend   <= 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    check("scan", {22'b0, an_vec, wxyz, pending, frame_tick},
          {22'b0, expect_out(t, m_shadow, m_pend)});
  end

  task automatic wait_phase(input int ph);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((t % FRAME) != ph && n < 3 * FRAME);
    if ((t % FRAME) != ph) check("wait_phase_timeout", 32'(t % FRAME), 32'(ph));
  endtask

  // Called at a negedge: load is high for exactly the current cycle.
  task automatic do_load(input logic [15:0] v);
    load     = 1'b1;
    value_in = v;
    @(negedge clk);
    load     = 1'b0;
  endtask

  task automatic check_digit(input string name, input int ph, input logic [3:0] an_exp,
                             input logic [3:0] nib_exp);
    wait_phase(ph);
    check({name, "_an"}, 32'(an_vec), 32'(an_exp));
    check({name, "_nib"}, 32'(wxyz), 32'(nib_exp));
  endtask

  initial begin
    int n;
    rst_n    = 1'b0;
    load     = 1'b0;
    value_in = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_an", 32'(an_vec), 32'hF);
    check("rst_nib", 32'(wxyz), 32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    #2 rst_n = 1'b1;

    // Idle scan after reset release.
    check_digit("idle_guard", 1, 4'b1111, 4'h0);
    check_digit("idle_d0", 2, 4'b1110, 4'h0);
    check_digit("idle_d0_end", 9, 4'b1110, 4'h0);
    check_digit("idle_d1_guard", 10, 4'b1111, 4'h0);
    wait_phase(FRAME - 1);
    check("tick_first", 32'(frame_tick), 32'h1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 2 * FRAME);
    check("tick_period", 32'(n), 32'(FRAME));

    // Mid-frame load is deferred to the next frame.
    wait_phase(15);
    do_load(16'h1A3F);
    check("load_pending", 32'(pending), 32'h1);
    check("load_no_early", 32'(wxyz), 32'h0);
    wait_phase(FRAME - 1);
    check("load_pending_tick", 32'(pending), 32'h1);
    check_digit("v1a3f_d0", 2, 4'b1110, 4'hF);
    check("v1a3f_pending", 32'(pending), 32'h0);
    check_digit("v1a3f_d1", 12, 4'b1101, 4'h3);
    check_digit("v1a3f_d2", 22, 4'b1011, 4'hA);
    check_digit("v1a3f_d3", 32, 4'b0111, 4'h1);

    // Two loads in one frame: last write wins.
    wait_phase(5);
    do_load(16'h1111);
    wait_phase(25);
    do_load(16'h2222);
    check_digit("lww_d0", 2, 4'b1110, 4'h2);
    check_digit("lww_d1", 12, 4'b1101, 4'h2);
    check_digit("lww_d2", 22, 4'b1011, 4'h2);
    check_digit("lww_d3", 32, 4'b0111, 4'h2);

    // Load on the boundary cycle bypasses staging.
    wait_phase(FRAME - 1);
    check("bypass_tick", 32'(frame_tick), 32'h1);
    do_load(16'hBEEF);
    check("bypass_guard_nib", 32'(wxyz), 32'hF);
    check("bypass_pending", 32'(pending), 32'h0);
    check_digit("beef_d0", 2, 4'b1110, 4'hF);
    check_digit("beef_d1", 12, 4'b1101, 4'hE);
    check_digit("beef_d3", 32, 4'b0111, 4'hB);

    // Reset mid digit-2 ON phase with a staged value.
    wait_phase(5);
    do_load(16'h1234);
    wait_phase(24);
    check("prerst_pending", 32'(pending), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_an", 32'(an_vec), 32'hF);
    check("async_rst_pending", 32'(pending), 32'h0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    check_digit("post_rst_guard", 1, 4'b1111, 4'h0);
    check_digit("post_rst_d0", 2, 4'b1110, 4'h0);
    check("post_rst_pending", 32'(pending), 32'h0);
    wait_phase(FRAME - 1);
    wait_phase(12);
    check("post_rst_d1_nib", 32'(wxyz), 32'h0);

    // Leading-zero handling on 16'h0050.
    wait_phase(5);
    do_load(16'h0050);
    check_digit("v0050_d0", 2, 4'b1110, 4'h0);
    check_digit("v0050_d1", 12, 4'b1101, 4'h5);
`ifdef SEG7_LZB_EN
    check_digit("v0050_d2", 22, 4'b1111, 4'h0);
    check_digit("v0050_d3", 32, 4'b1111, 4'h0);
    wait_phase(5);
    do_load(16'h0000);
    check_digit("v0000_d0", 2, 4'b1110, 4'h0);
    check_digit("v0000_d1", 12, 4'b1111, 4'h0);
`else
    check_digit("v0050_d2", 22, 4'b1011, 4'h0);
    check_digit("v0050_d3", 32, 4'b0111, 4'h0);
`endif
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
